// File: rtl/ula_rpn_stack_if.sv
// Request/response bundle for the RPN stack ALU.
interface ula_rpn_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic             push_valid;
  logic [WIDTH-1:0] push_data;
  logic             op_valid;
  logic [2:0]       op_sel;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    count;
  logic [4:0]       flags;

  modport master (
    output push_valid, push_data,
    output op_valid, op_sel, cin,
    input  busy, done, top, rem,
    input  count, flags
  );

  modport slave (
    input  push_valid, push_data,
    input  op_valid, op_sel, cin,
    output busy, done, top, rem,
    output count, flags
  );
endinterface

// File: rtl/ula_rpn_stack.sv
// RPN stack ALU: LIFO operand stack, single-cycle ops, serial divide.
// Define ULA_RPN_MUL_EN to build the multiplier.
module ula_rpn_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  ula_rpn_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    WB
  } state_t;

  state_t st, st_n;

  logic [WIDTH-1:0] stk [DEPTH];
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [4:0]       flg;
  logic             done_q;
  logic             drop_q;

  logic [WIDTH-1:0] dq, dr, dd;
  logic [SW-1:0]    step;

  logic [IW-1:0]    ti, ni, pi;
  logic [WIDTH-1:0] a, b, res;
  logic [WIDTH:0]   sum, dif;
  logic             cf, vf;
  logic             need2, short;
  logic             divz, nomul, bad;
  logic             is_div, last;

  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rn, qn;

  assign ti = IW'(cnt - CW'(1));
  assign ni = IW'(cnt - CW'(2));
  assign pi = IW'(cnt);

  assign a = stk[ni];
  assign b = stk[ti];

  assign sum = {1'b0, a} + {1'b0, b}
             + {{WIDTH{1'b0}}, bus.cin};
  assign dif = {1'b0, a} - {1'b0, b}
             - {{WIDTH{1'b0}}, bus.cin};

`ifdef ULA_RPN_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, a}
              * {{WIDTH{1'b0}}, b};
  assign nomul = 1'b0;
`else
  assign nomul = (bus.op_sel == OP_MUL);
`endif

  always_comb begin
    res = '0;
    cf  = 1'b0;
    vf  = 1'b0;
    unique case (bus.op_sel)
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        cf  = sum[WIDTH];
        vf  = (a[WIDTH-1] == b[WIDTH-1])
           && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res = dif[WIDTH-1:0];
        cf  = dif[WIDTH];
        vf  = (a[WIDTH-1] != b[WIDTH-1])
           && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: begin
`ifdef ULA_RPN_MUL_EN
        res = prod[WIDTH-1:0];
        vf  = |prod[2*WIDTH-1:WIDTH];
`endif
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~b;
      default: res = '0;
    endcase
  end

  assign need2  = (bus.op_sel != OP_NOT);
  assign short  = need2 ? (cnt < CW'(2))
                        : (cnt == '0);
  assign is_div = (bus.op_sel == OP_DIV);
  assign divz   = is_div && (b == '0);
  assign bad    = short || divz || nomul;

  // One restoring step: shift in next dividend bit, trial-subtract.
  assign trial = {dr, dq[WIDTH-1]};
  assign ge    = (trial >= {1'b0, dd});
  assign rn    = ge ? WIDTH'(trial - {1'b0, dd})
                    : trial[WIDTH-1:0];
  assign qn    = {dq[WIDTH-2:0], ge};
  assign last  = (step == SW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_n;
  end

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE: begin
        if (bus.op_valid && is_div && !bad)
          st_n = DIV;
      end
      DIV: begin
        if (last) st_n = WB;
      end
      WB:      st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        stk[i] <= '0;
      cnt    <= '0;
      rem_q  <= '0;
      flg    <= '0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
      dq     <= '0;
      dr     <= '0;
      dd     <= '0;
      step   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (st)
        IDLE: begin
          if (bus.op_valid) begin
            if (bad) begin
              flg    <= 5'b01000;
              done_q <= 1'b1;
            end else if (is_div) begin
              dq     <= a;
              dd     <= b;
              dr     <= '0;
              step   <= '0;
              drop_q <= bus.push_valid;
            end else begin
              if (need2) begin
                stk[ni] <= res;
                cnt     <= cnt - CW'(1);
              end else begin
                stk[ti] <= res;
              end
              flg <= {1'b0, bus.push_valid,
                      !bus.push_valid && (res == '0),
                      vf, cf};
              done_q <= 1'b1;
            end
          end else if (bus.push_valid) begin
            if (cnt == CW'(DEPTH)) begin
              flg[3] <= 1'b1;
              flg[2] <= 1'b0;
            end else begin
              stk[pi] <= bus.push_data;
              cnt     <= cnt + CW'(1);
              flg[3]  <= 1'b0;
            end
            done_q <= 1'b1;
          end
        end
        DIV: begin
          dr   <= rn;
          dq   <= qn;
          step <= step + SW'(1);
          if (last) begin
            stk[ni] <= qn;
            cnt     <= cnt - CW'(1);
            rem_q   <= rn;
            flg     <= {rn != '0, drop_q,
                        !drop_q && (qn == '0),
                        2'b00};
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (st != IDLE);
  assign bus.done  = done_q;
  assign bus.top   = (cnt == '0) ? '0 : stk[ti];
  assign bus.rem   = rem_q;
  assign bus.count = cnt;
  assign bus.flags = flg;
endmodule

// File: tb/tb_ula_rpn_stack.sv
// Directed scoreboard bench for ula_rpn_stack (WIDTH=8, DEPTH=4).
module tb_ula_rpn_stack;
  logic clk;
  logic rst_n;

  ula_rpn_stack_if #(.WIDTH(8), .DEPTH(4)) bus ();

  ula_rpn_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] top;
    logic [2:0] cnt;
    logic [4:0] flg;
    logic [4:0] lat;
  } exp_t;

  exp_t sb [$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.push_valid = 1'b0;
    bus.op_valid   = 1'b0;
    bus.cin        = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic expect_res(input logic [7:0] et,
                            input logic [2:0] ec,
                            input logic [4:0] ef,
                            input int lat);
    exp_t e;
    e.top = et;
    e.cnt = ec;
    e.flg = ef;
    e.lat = 5'(lat);
    sb.push_back(e);
  endtask

  task automatic drive_op(input logic [2:0] op,
                          input logic c,
                          input logic pv,
                          input logic [7:0] pd);
    bus.op_valid   = 1'b1;
    bus.op_sel     = op;
    bus.cin        = c;
    bus.push_valid = pv;
    bus.push_data  = pd;
    tick();
    bus.op_valid   = 1'b0;
    bus.push_valid = 1'b0;
    bus.cin        = 1'b0;
  endtask

  task automatic retire(input string tag,
                        input int n0);
    int n;
    exp_t e;
    n = n0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(e.lat));
    chk({tag, "_top"}, 32'(bus.top), 32'(e.top));
    chk({tag, "_cnt"}, 32'(bus.count), 32'(e.cnt));
    chk({tag, "_flg"}, 32'(bus.flags), 32'(e.flg));
    tick();
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
  endtask

  task automatic push(input string tag,
                      input logic [7:0] d,
                      input logic [2:0] ec,
                      input logic [4:0] ef,
                      input logic [7:0] et);
    expect_res(et, ec, ef, 1);
    bus.push_valid = 1'b1;
    bus.push_data  = d;
    tick();
    bus.push_valid = 1'b0;
    retire(tag, 1);
  endtask

  task automatic op(input string tag,
                    input logic [2:0] o,
                    input logic c,
                    input logic [7:0] et,
                    input logic [2:0] ec,
                    input logic [4:0] ef);
    expect_res(et, ec, ef, 1);
    drive_op(o, c, 1'b0, 8'd0);
    retire(tag, 1);
  endtask

  initial begin
    bit seen;
    bus.push_valid = 1'b0;
    bus.push_data  = '0;
    bus.op_valid   = 1'b0;
    bus.op_sel     = '0;
    bus.cin        = 1'b0;
    do_reset();

    chk("rst_top", 32'(bus.top), 32'd0);
    chk("rst_cnt", 32'(bus.count), 32'd0);
    chk("rst_flg", 32'(bus.flags), 32'd0);
    chk("rst_rem", 32'(bus.rem), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);

    op("empty_add", 3'd0, 1'b0, 8'd0, 3'd0, 5'b01000);
    push("a_p1", 8'd200, 3'd1, 5'b00000, 8'd200);
    push("a_p2", 8'd100, 3'd2, 5'b00000, 8'd100);
    op("add_c", 3'd0, 1'b0, 8'd44, 3'd1, 5'b00001);

    do_reset();
    push("d_p1", 8'd100, 3'd1, 5'b00000, 8'd100);
    push("d_p2", 8'd7, 3'd2, 5'b00000, 8'd7);
    expect_res(8'd14, 3'd1, 5'b10000, 9);
    drive_op(3'd3, 1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("div_busy%0d", i),
          32'(bus.busy), 32'd1);
      chk($sformatf("div_nodone%0d", i),
          32'(bus.done), 32'd0);
      bus.push_valid = (i == 3);
      bus.push_data  = 8'd55;
      tick();
    end
    bus.push_valid = 1'b0;
    chk("div_wb_busy", 32'(bus.busy), 32'd1);
    retire("div", 9);
    chk("div_rem", 32'(bus.rem), 32'd2);
    chk("div_idle", 32'(bus.busy), 32'd0);

    push("z_p1", 8'd5, 3'd2, 5'b10000, 8'd5);
    push("z_p2", 8'd0, 3'd3, 5'b10000, 8'd0);
    op("divz", 3'd3, 1'b0, 8'd0, 3'd3, 5'b01000);
    chk("divz_rem", 32'(bus.rem), 32'd2);

    do_reset();
    push("s_p1", 8'd5, 3'd1, 5'b00000, 8'd5);
    push("s_p2", 8'd10, 3'd2, 5'b00000, 8'd10);
    op("sub_b", 3'd1, 1'b1, 8'd250, 3'd1, 5'b00001);
    push("s_p3", 8'd128, 3'd2, 5'b00001, 8'd128);
    push("s_p4", 8'd1, 3'd3, 5'b00001, 8'd1);
    op("sub_v", 3'd1, 1'b0, 8'd127, 3'd2, 5'b00010);
    push("s_p5", 8'd1, 3'd3, 5'b00010, 8'd1);
    op("add_v", 3'd0, 1'b1, 8'd129, 3'd2, 5'b00010);

    op("xor", 3'd6, 1'b0, 8'd123, 3'd1, 5'b00000);
    op("not", 3'd7, 1'b0, 8'd132, 3'd1, 5'b00000);
    push("l_p1", 8'd132, 3'd2, 5'b00000, 8'd132);
    op("xor_z", 3'd6, 1'b0, 8'd0, 3'd1, 5'b00100);
    op("and_short", 3'd4, 1'b0, 8'd0, 3'd1, 5'b01000);
    push("l_p2", 8'd15, 3'd2, 5'b00000, 8'd15);
    op("or", 3'd5, 1'b0, 8'd15, 3'd1, 5'b00000);
    push("l_p3", 8'd3, 3'd2, 5'b00000, 8'd3);
    expect_res(8'd3, 3'd1, 5'b01000, 1);
    drive_op(3'd4, 1'b0, 1'b1, 8'd99);
    retire("both", 1);

    do_reset();
    push("f_p1", 8'd1, 3'd1, 5'b00000, 8'd1);
    push("f_p2", 8'd2, 3'd2, 5'b00000, 8'd2);
    push("f_p3", 8'd3, 3'd3, 5'b00000, 8'd3);
    push("f_p4", 8'd4, 3'd4, 5'b00000, 8'd4);
    push("f_full", 8'd5, 3'd4, 5'b01000, 8'd4);
    op("f_not", 3'd7, 1'b0, 8'd251, 3'd4, 5'b00000);

    do_reset();
    push("m_p1", 8'd16, 3'd1, 5'b00000, 8'd16);
    push("m_p2", 8'd16, 3'd2, 5'b00000, 8'd16);
`ifdef ULA_RPN_MUL_EN
    op("mul_ov", 3'd2, 1'b0, 8'd0, 3'd1, 5'b00110);
    push("m_p3", 8'd3, 3'd2, 5'b00110, 8'd3);
    op("mul_z", 3'd2, 1'b0, 8'd0, 3'd1, 5'b00100);
`else
    op("mul_off", 3'd2, 1'b0, 8'd16, 3'd2, 5'b01000);
    push("m_p3", 8'd3, 3'd3, 5'b00000, 8'd3);
    op("mul_off2", 3'd2, 1'b0, 8'd3, 3'd3, 5'b01000);
`endif

    do_reset();
    push("r_p1", 8'd100, 3'd1, 5'b00000, 8'd100);
    push("r_p2", 8'd3, 3'd2, 5'b00000, 8'd3);
    drive_op(3'd3, 1'b0, 1'b0, 8'd0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rdiv_cnt", 32'(bus.count), 32'd0);
    chk("rdiv_busy", 32'(bus.busy), 32'd0);
    chk("rdiv_top", 32'(bus.top), 32'd0);
    chk("rdiv_done", 32'(bus.done), 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("rdiv_nowb", 32'(seen), 32'd0);
    chk("rdiv_cnt2", 32'(bus.count), 32'd0);
    chk("rdiv_busy2", 32'(bus.busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
